multiplexor_nin_1out_stream: RTL and testbench
==============================================

MULTIPLEXOR_NIN_1OUT_STREAM -- requirements
Module: multiplexor_nin_1out_stream

Interface
REQ-001 Parameter DB, default 16, data width in bits of each channel and of the output.
REQ-002 Parameter NCH, default 4, number of input channels; legal range 2..16.
REQ-003 Parameter MODE, default 1, arbitration mode: 0 = fixed priority (lowest index wins), 1 = round-robin.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_data  input  NCH*DB  channel i data in bits [i*DB+DB-1 : i*DB].
REQ-007 in_valid  input  NCH  per-channel valid.
REQ-008 in_last  input  NCH  per-channel end-of-packet marker, qualified by in_valid.
REQ-009 in_ready  output  NCH  per-channel ready; at most one bit high in any cycle.
REQ-010 out_data  output  DB  registered output data.
REQ-011 out_valid  output  1  registered output valid.
REQ-012 out_last  output  1  registered end-of-packet marker.
REQ-013 out_sel  output  $clog2(NCH)  registered index of the channel that produced the current output beat.
REQ-014 out_ready  input  1  downstream ready.

Function
REQ-015 A beat SHALL transfer on an input when in_valid[i] and in_ready[i] are both high at a rising edge, and on the output when out_valid and out_ready are both high.
REQ-016 load_en = !out_valid || out_ready; in_ready SHALL be zero whenever load_en is low.
REQ-017 State machine: IDLE (no packet owns the output) and LOCKED (packet in progress on channel grant).
REQ-018 In IDLE, the winner is selected combinationally among asserted in_valid: MODE 0 picks the lowest index; MODE 1 picks the first asserted index searching upward from rr_ptr, wrapping from NCH-1 to 0.
REQ-019 In IDLE with load_en high and a winner w, in_ready[w] SHALL be high in the same cycle (zero-bubble grant).
REQ-020 In LOCKED, in_ready[grant] = load_en; all other in_ready bits SHALL be low, regardless of their in_valid.
REQ-021 On an input transfer from channel c: out_data, out_last and out_sel SHALL load channel c's data, in_last[c] and c, and out_valid SHALL be set on that edge (latency one cycle).
REQ-022 When load_en is high and no input transfer occurs, out_valid SHALL clear; out_data, out_last and out_sel SHALL hold.
REQ-023 When load_en is low, all output registers SHALL hold their values.
REQ-024 IDLE -> LOCKED on a transfer with in_last[c]=0, latching grant=c; a transfer with in_last[c]=1 in IDLE SHALL stay in IDLE (single-beat packet).
REQ-025 LOCKED -> IDLE on a transfer from grant with in_last=1; LOCKED holds otherwise, including cycles where in_valid[grant] is low.
REQ-026 In MODE 1, rr_ptr SHALL update to (c+1) mod NCH on the edge that transfers the last beat of a packet from channel c; in MODE 0, rr_ptr is unused.
REQ-027 Simultaneous output drain and input load in one cycle SHALL sustain one beat per cycle with no bubble.
REQ-028 Data SHALL pass bit-exact; no width conversion or sign handling.

Reset
REQ-029 While reset is high at a rising edge: state=IDLE, grant=0, rr_ptr=0, out_valid=0, out_last=0, out_data=0, out_sel=0.
REQ-030 During and in the cycle of reset, in_ready SHALL be all zeros; a packet interrupted by reset SHALL be abandoned, with no beat of it emitted afterwards unless re-presented.
REQ-031 Reset SHALL take priority over any simultaneous transfer.

Verification
REQ-032 NCH=4, MODE=1, out_ready=1, all in_valid=1, in_last=1 on every beat -> out_sel sequence 0,1,2,3,0 on consecutive cycles, out_valid continuously 1.
REQ-033 MODE=0, all in_valid=1, single-beat packets -> out_sel=0 every cycle; channels 1..3 never see in_ready.
REQ-034 Ch2 sends a 3-beat packet (0xA001, 0xA002, 0xA003 with last on the third) while ch0 asserts valid with 0x0BEE -> output 0xA001, 0xA002, 0xA003 (out_last=1 on 0xA003) then 0x0BEE; ch0 in_ready low until 0xA003 transfers.
REQ-035 out_valid=1 with out_data=0x1234 and out_ready held 0 for 5 cycles -> out_data stays 0x1234, in_ready=0; on out_ready=1 the next beat appears on the following edge.
REQ-036 Reset asserted after the 2nd beat of a 4-beat packet on ch1 -> next edge out_valid=0, state IDLE, rr_ptr=0; after release, ch3 valid with 0x0033 is granted and emitted with out_sel=3.
REQ-037 Random valid/last/out_ready for 10,000 cycles with a scoreboard -> per-channel order preserved, packets never interleaved, in_ready at most one-hot, no beat lost or duplicated.

Source files
------------

// File: rtl/multiplexor_nin_1out_stream.sv
// N-input to 1-output stream multiplexer with packet locking.
// Arbitration is fixed-priority (MODE 0) or round-robin (MODE 1), with a registered output stage.
module multiplexor_nin_1out_stream #(
    parameter int unsigned DB   = 16,
    parameter int unsigned NCH  = 4,
    parameter int unsigned MODE = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NCH*DB-1:0]        in_data,
    input  logic [NCH-1:0]           in_valid,
    input  logic [NCH-1:0]           in_last,
    output logic [NCH-1:0]           in_ready,
    output logic [DB-1:0]            out_data,
    output logic                     out_valid,
    output logic                     out_last,
    output logic [$clog2(NCH)-1:0]   out_sel,
    input  logic                     out_ready
);

    localparam int unsigned SW  = $clog2(NCH);
    localparam int unsigned SWP = SW + 1;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t          state, state_nxt;
    logic [SW-1:0]   grant, grant_nxt;
    logic [SW-1:0]   rr_ptr, rr_nxt;
    logic            load_en_c;
    logic            win_found;
    logic [SW-1:0]   win_idx;
    logic [SW:0]     scan_idx;
    logic            xfer;
    logic [SW-1:0]   xfer_idx;
    logic [DB-1:0]   xfer_data;
    logic            xfer_last;

    assign load_en_c = !out_valid || out_ready;

    // Winner search upward from rr_ptr; rr_ptr stays 0 in MODE 0, giving lowest-index priority.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            scan_idx = {1'b0, rr_ptr} + SWP'(k);
            if (scan_idx >= SWP'(NCH)) begin
                scan_idx = scan_idx - SWP'(NCH);
            end
            if (in_valid[scan_idx[SW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = scan_idx[SW-1:0];
            end
        end
    end

    // Grant, transfer detection and next-state logic.
    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        rr_nxt    = rr_ptr;
        in_ready  = '0;
        xfer      = 1'b0;
        xfer_idx  = '0;
        xfer_data = '0;
        xfer_last = 1'b0;

        if (!reset && load_en_c) begin
            if (state == LOCKED) begin
                in_ready[grant] = 1'b1;
            end else if (win_found) begin
                in_ready[win_idx] = 1'b1;
            end
        end

        for (int i = 0; i < NCH; i++) begin
            if (in_valid[i] && in_ready[i]) begin
                xfer      = 1'b1;
                xfer_idx  = SW'(i);
                xfer_data = in_data[i*DB +: DB];
                xfer_last = in_last[i];
            end
        end

        case (state)
            IDLE: begin
                if (xfer && !xfer_last) begin
                    state_nxt = LOCKED;
                    grant_nxt = xfer_idx;
                end
            end
            LOCKED: begin
                if (xfer && xfer_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (MODE == 1 && xfer && xfer_last) begin
            rr_nxt = (xfer_idx == SW'(NCH - 1)) ? '0 : xfer_idx + SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= '0;
        end else begin
            state  <= state_nxt;
            grant  <= grant_nxt;
            rr_ptr <= rr_nxt;
        end
    end

    // Output stage: load on transfer, drop valid when drained with nothing new, hold when stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
        end else if (load_en_c) begin
            out_valid <= xfer;
            if (xfer) begin
                out_data <= xfer_data;
                out_last <= xfer_last;
                out_sel  <= xfer_idx;
            end
        end
    end

endmodule

// File: tb/tb_multiplexor_nin_1out_stream.sv
// Scoreboard bench for multiplexor_nin_1out_stream: packet-level arbitration model,
// directed scenarios and a long randomized run.
module tb_multiplexor_nin_1out_stream;

    localparam int unsigned DB   = 16;
    localparam int unsigned NCH  = 4;
    localparam int unsigned MODE = 1;
    localparam int unsigned SW   = 2;

    typedef struct packed {
        logic [DB-1:0] data;
        logic          last;
    } beat_t;

    typedef struct packed {
        logic [DB-1:0] data;
        logic          last;
        logic [SW-1:0] sel;
    } out_t;

    logic              clk = 1'b0;
    logic              reset;
    logic [NCH*DB-1:0] in_data;
    logic [NCH-1:0]    in_valid;
    logic [NCH-1:0]    in_last;
    logic [NCH-1:0]    in_ready;
    logic [DB-1:0]     out_data;
    logic              out_valid;
    logic              out_last;
    logic [SW-1:0]     out_sel;
    logic              out_ready;

    logic              fp_reset;
    logic [NCH*DB-1:0] fp_in_data;
    logic [NCH-1:0]    fp_in_ready;
    logic [DB-1:0]     fp_out_data;
    logic              fp_out_valid;
    logic              fp_out_last;
    logic [SW-1:0]     fp_out_sel;

    always #5 clk = ~clk;

    multiplexor_nin_1out_stream #(.DB(DB), .NCH(NCH), .MODE(MODE)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .out_data(out_data),
        .out_valid(out_valid), .out_last(out_last), .out_sel(out_sel),
        .out_ready(out_ready)
    );

    // Fixed-priority instance with every channel permanently offering single-beat packets.
    multiplexor_nin_1out_stream #(.DB(DB), .NCH(NCH), .MODE(0)) dut_fp (
        .clk(clk), .reset(fp_reset), .in_data(fp_in_data), .in_valid(4'hF),
        .in_last(4'hF), .in_ready(fp_in_ready), .out_data(fp_out_data),
        .out_valid(fp_out_valid), .out_last(fp_out_last), .out_sel(fp_out_sel),
        .out_ready(1'b1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    beat_t          chq[NCH][$];
    out_t           exp_q[$];
    logic [DB-1:0]  data_log[$];
    bit             eager = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_beat(input int ch, input logic [DB-1:0] d, input bit l);
        beat_t b;
        b.data = d;
        b.last = l;
        chq[ch].push_back(b);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_out(input string name, input logic [DB-1:0] d);
        bit found;
        found = 1'b0;
        for (int n = 0; n < 60 && !found; n++) begin
            step();
            if (out_valid && out_data == d) found = 1'b1;
        end
        check(name, 64'(found), 64'(1));
    endtask

    task automatic drain(input string name);
        bit done;
        done = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 200 && !done; n++) begin
            step();
            done = (chq[0].size() + chq[1].size() + chq[2].size() + chq[3].size() == 0)
                   && !out_valid && exp_q.size() == 0;
        end
        check(name, 64'(done), 64'(1));
    endtask

    // Reference model: packet ownership plus a round-robin pointer, evaluated per cycle.
    int            m_owner = -1;
    int            m_rr    = 0;
    bit            m_ov    = 1'b0;
    initial begin
        logic [NCH-1:0] exp_rdy;
        bit             le;
        bit             found;
        int             c;
        int             j;
        out_t           o;
        forever begin
            @(negedge clk);
            exp_rdy = '0;
            c       = -1;
            found   = 1'b0;
            le      = !m_ov || out_ready;
            if (!reset && le) begin
                if (m_owner >= 0) begin
                    exp_rdy[m_owner] = 1'b1;
                end else begin
                    for (int k = 0; k < NCH; k++) begin
                        j = (m_rr + k) % NCH;
                        if (!found && in_valid[j]) begin
                            exp_rdy[j] = 1'b1;
                            found      = 1'b1;
                        end
                    end
                end
            end
            check("in_ready", 64'(in_ready), 64'(exp_rdy));
            for (int k = 0; k < NCH; k++) begin
                if (exp_rdy[k] && in_valid[k]) c = k;
            end
            if (c >= 0) begin
                o.data = in_data[c*DB +: DB];
                o.last = in_last[c];
                o.sel  = SW'(c);
            end
            @(posedge clk);
            if (reset) begin
                m_ov    = 1'b0;
                m_owner = -1;
                m_rr    = 0;
                exp_q.delete();
            end else if (le) begin
                if (c >= 0) begin
                    exp_q.push_back(o);
                    m_ov = 1'b1;
                    if (o.last) begin
                        m_owner = -1;
                        if (MODE == 1) m_rr = (c + 1) % NCH;
                    end else begin
                        m_owner = c;
                    end
                end else begin
                    m_ov = 1'b0;
                end
            end
        end
    end

    // Monitor: every output beat accepted downstream must match the scoreboard head.
    initial begin
        out_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
                if (out_valid && out_ready && exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("out_data", 64'(out_data), 64'(e.data));
                    check("out_last", 64'(out_last), 64'(e.last));
                    check("out_sel",  64'(out_sel),  64'(e.sel));
                    data_log.push_back(out_data);
                end
            end
        end
    end

    // Channel driver: presents each queue head, holds it until accepted.
    initial begin
        bit acc[NCH];
        bit hold;
        in_valid = '0;
        in_last  = '0;
        in_data  = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NCH; i++) acc[i] = in_valid[i] && in_ready[i] && !reset;
            @(posedge clk);
            #1;
            for (int i = 0; i < NCH; i++) begin
                if (acc[i] && chq[i].size() != 0) void'(chq[i].pop_front());
                if (chq[i].size() != 0) begin
                    hold = in_valid[i] && !acc[i];
                    if (eager || hold || $urandom_range(99) < 70) begin
                        in_valid[i]          = 1'b1;
                        in_data[i*DB +: DB]  = chq[i][0].data;
                        in_last[i]           = chq[i][0].last;
                    end else begin
                        in_valid[i] = 1'b0;
                    end
                end else begin
                    in_valid[i] = 1'b0;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seq;
        int len;
        reset      = 1'b1;
        fp_reset   = 1'b1;
        out_ready  = 1'b1;
        fp_in_data = {16'h3333, 16'h2222, 16'h1111, 16'h0000};
        step();
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_data",  64'(out_data),  64'(0));
        check("rst_out_last",  64'(out_last),  64'(0));
        check("rst_out_sel",   64'(out_sel),   64'(0));
        check("rst_in_ready",  64'(in_ready),  64'(0));
        step();
        reset    = 1'b0;
        fp_reset = 1'b0;

        // Round-robin over continuously offered single-beat packets.
        for (int n = 0; n < 3; n++)
            for (int i = 0; i < NCH; i++) push_beat(i, DB'(16'hC000 + i * 16 + n), 1'b1);
        begin
            bit seen;
            seen = 1'b0;
            for (int n = 0; n < 20 && !seen; n++) begin
                step();
                seen = out_valid;
            end
            check("rr_start", 64'(seen), 64'(1));
        end
        for (int k = 0; k < 12; k++) begin
            check("rr_seq",     64'(out_sel),     64'(k % NCH));
            check("rr_cont",    64'(out_valid),   64'(1));
            check("fp_ready",   64'(fp_in_ready), 64'(4'b0001));
            check("fp_sel",     64'(fp_out_sel),  64'(0));
            check("fp_data",    64'(fp_out_data), 64'(16'h0000));
            check("fp_valid",   64'(fp_out_valid),64'(1));
            step();
        end
        drain("drain_rr");

        // Locked 3-beat packet on ch2 must not be interleaved with ch0.
        data_log.delete();
        push_beat(2, 16'hA001, 1'b0);
        push_beat(2, 16'hA002, 1'b0);
        push_beat(2, 16'hA003, 1'b1);
        step();
        push_beat(0, 16'h0BEE, 1'b1);
        for (int n = 0; n < 40 && data_log.size() < 4; n++) step();
        check("lock_cnt", 64'(data_log.size()), 64'(4));
        if (data_log.size() >= 4) begin
            check("lock_b0", 64'(data_log[0]), 64'(16'hA001));
            check("lock_b1", 64'(data_log[1]), 64'(16'hA002));
            check("lock_b2", 64'(data_log[2]), 64'(16'hA003));
            check("lock_b3", 64'(data_log[3]), 64'(16'h0BEE));
        end
        drain("drain_lock");

        // Backpressure: output holds while out_ready is low.
        push_beat(0, 16'h1234, 1'b1);
        wait_out("bp_first", 16'h1234);
        out_ready = 1'b0;
        push_beat(1, 16'h5678, 1'b1);
        for (int n = 0; n < 5; n++) begin
            step();
            check("bp_hold_data",  64'(out_data),  64'(16'h1234));
            check("bp_hold_valid", 64'(out_valid), 64'(1));
            check("bp_hold_ready", 64'(in_ready),  64'(0));
        end
        out_ready = 1'b1;
        step();
        check("bp_next_data", 64'(out_data),  64'(16'h5678));
        check("bp_next_sel",  64'(out_sel),   64'(1));
        check("bp_next_vld",  64'(out_valid), 64'(1));
        drain("drain_bp");

        // Reset in the middle of a 4-beat packet on ch1.
        for (int n = 0; n < 4; n++) push_beat(1, DB'(16'h1100 + n), n == 3);
        wait_out("mid_beat2", 16'h1101);
        reset = 1'b1;
        for (int i = 0; i < NCH; i++) chq[i].delete();
        step();
        check("mid_rst_valid", 64'(out_valid), 64'(0));
        check("mid_rst_ready", 64'(in_ready),  64'(0));
        reset = 1'b0;
        push_beat(3, 16'h0033, 1'b1);
        wait_out("post_rst_beat", 16'h0033);
        check("post_rst_sel", 64'(out_sel), 64'(3));
        drain("drain_rst");

        // Randomized traffic with random downstream stalls.
        eager = 1'b0;
        seq   = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            for (int i = 0; i < NCH; i++) begin
                if (chq[i].size() < 3) begin
                    len = int'($urandom_range(4, 1));
                    for (int b = 0; b < len; b++) begin
                        push_beat(i, {4'(i), 12'(seq)}, b == len - 1);
                        seq++;
                    end
                end
            end
            out_ready = ($urandom_range(99) < 75);
            step();
        end
        eager = 1'b1;
        drain("drain_rand");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
